// File: rtl/can_tx_arbiter_if.sv
// Request-side and CAN-transmit-side bus bundle for can_tx_arbiter.
// The requester/CAN-core environment uses the master modport; the arbiter uses slave.
interface can_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [31:0]        tx_data;
  logic [2:0]         tx_src;

  modport master (
    output req_valid,
    output req_data,
    output tx_ready,
    input  req_ready,
    input  tx_valid,
    input  tx_data,
    input  tx_src
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_ready,
    output req_ready,
    output tx_valid,
    output tx_data,
    output tx_src
  );
endinterface

// File: rtl/can_tx_arbiter.sv
// Round-robin arbiter funnelling NREQ 32-bit requesters onto one CAN tx port.
// One word is held on tx_data until the CAN core takes it, followed by an optional
// idle gap before the next grant.
//
// state | meaning
// IDLE  | arbitrating; req_ready offered to the round-robin winner
// HOLD  | word presented on tx_data, waiting for tx_ready
// GAP   | enforced idle clocks after a handshake, no grants
module can_tx_arbiter #(
  parameter int          NREQ       = 4,
  parameter logic [15:0] GAP_CYCLES = 16'd0
) (
  input  logic              clk,
  input  logic              rstn,
  can_tx_arbiter_if.slave   bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] gap_cnt;
  logic [15:0] gap_cnt_nxt;
  logic [2:0]  last_grant;
  logic [2:0]  sel;
  logic        any_valid;
  logic [7:0]  valid_pad;
  logic [31:0] sel_word;
  logic        accept;
  logic [31:0] tx_data_q;
  logic [2:0]  tx_src_q;

  // Round-robin pick: scan downward so the nearest requester after last_grant wins.
  always_comb begin
    int idx;
    valid_pad            = '0;
    valid_pad[NREQ-1:0]  = bus.req_valid;
    sel                  = '0;
    any_valid            = 1'b0;
    idx                  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (valid_pad[idx[2:0]]) begin
        sel       = idx[2:0];
        any_valid = 1'b1;
      end
    end
  end

  // Data mux for the selected requester's word.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == sel) sel_word = bus.req_data[32*i +: 32];
    end
  end

  // Accept strobe is offered only in IDLE, only to the winner, and never in reset.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = rstn && (state == IDLE) && any_valid && (3'(i) == sel);
    end
  end

  // Next-state and gap counter logic.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.tx_ready) begin
          if (GAP_CYCLES == 16'd0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_CYCLES - 16'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 16'd0) state_nxt = IDLE;
        else                  gap_cnt_nxt = gap_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      gap_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Capture the granted word; it persists through IDLE and GAP until the next grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data_q  <= 32'd0;
      tx_src_q   <= 3'd0;
      last_grant <= 3'(NREQ - 1);
    end else if (accept) begin
      tx_data_q  <= sel_word;
      tx_src_q   <= sel;
      last_grant <= sel;
    end
  end

  // tx_valid decodes HOLD directly so reset clears it without waiting for a clock.
  assign bus.tx_valid = (state == HOLD);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_src   = tx_src_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Bench for can_tx_arbiter: one instance with no gap, one with a 3-clock gap,
// both fed the same stimulus; directed scenarios then a randomized run against
// a transaction-level model.
module tb_can_tx_arbiter;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic         tx_ready;
  logic         busy0;
  logic         busy3;

  int n_cmp;
  int n_bad;

  can_tx_arbiter_if #(.NREQ(4)) bus0 ();
  can_tx_arbiter_if #(.NREQ(4)) bus3 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_data  = req_data;
  assign bus0.tx_ready  = tx_ready;
  assign bus3.req_valid = req_valid;
  assign bus3.req_data  = req_data;
  assign bus3.tx_ready  = tx_ready;

  can_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16'd0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0),
    .busy (busy0)
  );

  can_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16'd3)) dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3),
    .busy (busy3)
  );

  logic [3:0]  o_rdy  [2];
  logic        o_txv  [2];
  logic [31:0] o_dat  [2];
  logic [2:0]  o_src  [2];
  logic        o_busy [2];

  assign o_rdy[0]  = bus0.req_ready;
  assign o_txv[0]  = bus0.tx_valid;
  assign o_dat[0]  = bus0.tx_data;
  assign o_src[0]  = bus0.tx_src;
  assign o_busy[0] = busy0;
  assign o_rdy[1]  = bus3.req_ready;
  assign o_txv[1]  = bus3.tx_valid;
  assign o_dat[1]  = bus3.tx_data;
  assign o_src[1]  = bus3.tx_src;
  assign o_busy[1] = busy3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = 4'b0000;
    tx_ready  = 1'b0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = 4'b1111;
    tx_ready  = 1'b1;
    req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_rdy[d] !== 4'b0000) begin n_bad++; $display("FAIL reset_ready dut%0d got %b want 0000", d, o_rdy[d]); end
      n_cmp++; if (o_txv[d] !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid dut%0d got %b want 0", d, o_txv[d]); end
      n_cmp++; if (o_dat[d] !== 32'd0) begin n_bad++; $display("FAIL reset_tx_data dut%0d got %h want 0", d, o_dat[d]); end
      n_cmp++; if (o_src[d] !== 3'd0) begin n_bad++; $display("FAIL reset_tx_src dut%0d got %0d want 0", d, o_src[d]); end
      n_cmp++; if (o_busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 0", d, o_busy[d]); end
    end
    // first priority after reset goes to requester 0
    rstn = 1'b1;
    #1;
    n_cmp++; if (o_rdy[0] !== 4'b0001) begin n_bad++; $display("FAIL reset_first_prio got %b want 0001", o_rdy[0]); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data  = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};
    tx_ready  = 1'b1;
    #1;
    n_cmp++; if (o_rdy[0] !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", o_rdy[0]); end
    @(negedge clk); #1;
    n_cmp++; if (o_txv[0] !== 1'b1) begin n_bad++; $display("FAIL single_tx_valid got %b want 1", o_txv[0]); end
    n_cmp++; if (o_dat[0] !== 32'hA5A5_0002) begin n_bad++; $display("FAIL single_tx_data got %h want a5a50002", o_dat[0]); end
    n_cmp++; if (o_src[0] !== 3'd2) begin n_bad++; $display("FAIL single_tx_src got %0d want 2", o_src[0]); end
    n_cmp++; if (o_rdy[0] !== 4'b0000) begin n_bad++; $display("FAIL single_hold_ready got %b want 0000", o_rdy[0]); end
    @(negedge clk); #1;
    n_cmp++; if (o_busy[0] !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", o_busy[0]); end
    n_cmp++; if (o_txv[0] !== 1'b0) begin n_bad++; $display("FAIL single_idle_tx_valid got %b want 0", o_txv[0]); end
    n_cmp++; if (o_dat[0] !== 32'hA5A5_0002) begin n_bad++; $display("FAIL single_retain_data got %h want a5a50002", o_dat[0]); end
    n_cmp++; if (o_rdy[0] !== 4'b0100) begin n_bad++; $display("FAIL single_lone_regrant got %b want 0100", o_rdy[0]); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_rotate();
    do_reset();
    req_valid = 4'b1111;
    req_data  = {32'hD000_0003, 32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
    tx_ready  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int g;
      g = (k / 2) % 4;
      #1;
      if (k % 2 == 0) begin
        n_cmp++; if (o_rdy[0] !== 4'(1 << g)) begin n_bad++; $display("FAIL rotate_ready cycle %0d got %b want grant %0d", k, o_rdy[0], g); end
      end else begin
        n_cmp++; if (o_txv[0] !== 1'b1) begin n_bad++; $display("FAIL rotate_tx_valid cycle %0d got %b want 1", k, o_txv[0]); end
        n_cmp++; if (o_src[0] !== 3'(g)) begin n_bad++; $display("FAIL rotate_tx_src cycle %0d got %0d want %0d", k, o_src[0], g); end
        n_cmp++; if (o_dat[0] !== req_data[32*g +: 32]) begin n_bad++; $display("FAIL rotate_tx_data cycle %0d got %h want %h", k, o_dat[0], req_data[32*g +: 32]); end
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0011;
    req_data  = {32'h0, 32'h0, 32'h1111_0001, 32'h0000_BEEF};
    tx_ready  = 1'b0;
    #1;
    n_cmp++; if (o_rdy[0] !== 4'b0001) begin n_bad++; $display("FAIL bp_grant got %b want 0001", o_rdy[0]); end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (o_txv[0] !== 1'b1 || o_dat[0] !== 32'h0000_BEEF || o_src[0] !== 3'd0 || o_rdy[0] !== 4'b0000) begin
        n_bad++; $display("FAIL bp_stall cycle %0d got v=%b d=%h s=%0d r=%b want v=1 d=0000beef s=0 r=0000", k, o_txv[0], o_dat[0], o_src[0], o_rdy[0]);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    #1;
    n_cmp++; if (o_txv[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_valid got %b want 1", o_txv[0]); end
    @(negedge clk); #1;
    n_cmp++; if (o_txv[0] !== 1'b0) begin n_bad++; $display("FAIL bp_after_hs_valid got %b want 0", o_txv[0]); end
    n_cmp++; if (o_rdy[0] !== 4'b0010) begin n_bad++; $display("FAIL bp_next_grant got %b want 0010", o_rdy[0]); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_gap();
    int gap_seen;
    bit done;
    do_reset();
    req_valid = 4'b0101;
    req_data  = {32'h0, 32'h2222_0002, 32'h0, 32'h0000_0000};
    tx_ready  = 1'b1;
    #1;
    n_cmp++; if (o_rdy[1] !== 4'b0001) begin n_bad++; $display("FAIL gap_first_grant got %b want 0001", o_rdy[1]); end
    @(negedge clk); #1;
    n_cmp++; if (o_txv[1] !== 1'b1) begin n_bad++; $display("FAIL gap_hold_valid got %b want 1", o_txv[1]); end
    @(negedge clk);
    gap_seen = 0;
    done     = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (o_rdy[1] !== 4'b0000) done = 1'b1;
      else begin
        if (o_busy[1] === 1'b1 && o_txv[1] === 1'b0) gap_seen++;
        @(negedge clk);
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL gap_timeout got no grant want grant within 20 clocks"); end
    n_cmp++; if (gap_seen !== 3) begin n_bad++; $display("FAIL gap_length got %0d want 3", gap_seen); end
    n_cmp++; if (o_rdy[1] !== 4'b0100) begin n_bad++; $display("FAIL gap_next_grant got %b want 0100", o_rdy[1]); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req_valid = 4'b0100;
    req_data  = {32'h0, 32'h7777_0002, 32'h0, 32'h0};
    tx_ready  = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (o_txv[0] !== 1'b1) begin n_bad++; $display("FAIL rst_hold_valid got %b want 1", o_txv[0]); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (o_txv[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid got %b want 0", o_txv[0]); end
    n_cmp++; if (o_busy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got %b want 0", o_busy[0]); end
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++; if (o_rdy[0] !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant got %b want 0001", o_rdy[0]); end
    n_cmp++; if (o_txv[0] !== 1'b0) begin n_bad++; $display("FAIL rst_no_stale_valid got %b want 0", o_txv[0]); end
    @(negedge clk); #1;
    n_cmp++; if (o_src[0] !== 3'd0 || o_txv[0] !== 1'b1) begin n_bad++; $display("FAIL rst_new_word got s=%0d v=%b want s=0 v=1", o_src[0], o_txv[0]); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_drop();
    bit saw1;
    saw1 = 1'b0;
    do_reset();
    req_valid = 4'b1000;
    req_data  = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0000_0000};
    tx_ready  = 1'b0;
    #1;
    n_cmp++; if (o_rdy[0] !== 4'b1000) begin n_bad++; $display("FAIL drop_grant3 got %b want 1000", o_rdy[0]); end
    @(negedge clk);
    req_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1; if (o_rdy[0][1] === 1'b1) saw1 = 1'b1;
      @(negedge clk);
    end
    req_valid = 4'b0001;
    tx_ready  = 1'b1;
    #1; if (o_rdy[0][1] === 1'b1) saw1 = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (o_rdy[0] !== 4'b0001) begin n_bad++; $display("FAIL drop_next_grant got %b want 0001", o_rdy[0]); end
    for (int k = 0; k < 6; k++) begin
      if (o_rdy[0][1] === 1'b1) saw1 = 1'b1;
      @(negedge clk); #1;
    end
    n_cmp++; if (saw1 !== 1'b0) begin n_bad++; $display("FAIL drop_req1_ready got %b want 0", saw1); end
    req_valid = 4'b0000;
    @(negedge clk);
  endtask

  // Transaction-level model: a word is either held (waiting for tx_ready) or not;
  // after a taken word the port stays closed for gap clocks; otherwise the
  // nearest valid requester after the last grant is offered.
  task automatic test_random();
    bit          m_hold [2];
    int          m_cool [2];
    int          m_last [2];
    logic [31:0] m_word [2];
    int          m_src  [2];
    int          gapv   [2];
    gapv = '{0, 3};
    do_reset();
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = 1'b0; m_cool[d] = 0; m_last[d] = 3; m_word[d] = 32'd0; m_src[d] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = 4'($urandom_range(0, 15));
      tx_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        int       g;
        logic [3:0] exp_rdy;
        g       = -1;
        exp_rdy = 4'b0000;
        if (!m_hold[d] && m_cool[d] == 0) begin
          for (int k = 4; k >= 1; k--) begin
            if (req_valid[(m_last[d] + k) % 4]) g = (m_last[d] + k) % 4;
          end
          if (g >= 0) exp_rdy = 4'(1 << g);
        end
        n_cmp++; if (o_rdy[d] !== exp_rdy || o_txv[d] !== m_hold[d] || o_busy[d] !== (m_hold[d] || m_cool[d] > 0) ||
                     o_dat[d] !== m_word[d] || o_src[d] !== 3'(m_src[d])) begin
          n_bad++;
          $display("FAIL random dut%0d cycle %0d got r=%b v=%b b=%b d=%h s=%0d want r=%b v=%b b=%b d=%h s=%0d",
                   d, cyc, o_rdy[d], o_txv[d], o_busy[d], o_dat[d], o_src[d],
                   exp_rdy, m_hold[d], (m_hold[d] || m_cool[d] > 0), m_word[d], m_src[d]);
        end
        if (m_hold[d]) begin
          if (tx_ready) begin m_hold[d] = 1'b0; m_cool[d] = gapv[d]; end
        end else if (m_cool[d] > 0) begin
          m_cool[d]--;
        end else if (g >= 0) begin
          m_hold[d] = 1'b1; m_word[d] = req_data[32*g +: 32]; m_src[d] = g; m_last[d] = g;
        end
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    tx_ready  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_rotate();
    test_backpressure();
    test_gap();
    test_reset_mid_hold();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
